// File: rtl/host_cmd_seq.sv
// Host-side command sequencer: sends a CMD_BYTES-byte command MSB-first to a byte
// UART transmitter, then collects a programmable number of response bytes.
`timescale 1ns/1ps

module host_cmd_seq #(
    parameter int          CMD_BYTES   = 3,
    parameter int          MAX_RESP    = 512,
    parameter int          TIMEOUT_CYC = 65535,
    parameter logic [7:0]  ACK_VAL     = 8'hA5,
    localparam int         RLW         = $clog2(MAX_RESP + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*CMD_BYTES-1:0] cmd,
    input  logic                   send_cmd,
    input  logic [RLW-1:0]         resp_len,
    input  logic                   chk_ack,
    output logic [7:0]             tx_data,
    output logic                   trmt,
    input  logic                   tx_done,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   clr_rx_rdy,
    output logic                   busy,
    output logic                   cmd_sent,
    output logic [7:0]             resp,
    output logic                   resp_vld,
    output logic [RLW-1:0]         resp_cnt,
    output logic                   done,
    output logic                   nak,
    output logic                   timeout,
    output logic [2:0]             state_dbg
);

    localparam int CW  = 8 * CMD_BYTES;
    localparam int BIW = $clog2(CMD_BYTES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(CMD_BYTES - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [RLW-1:0] MAX_LEN   = RLW'(MAX_RESP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_LOAD = 3'd1,
        TX_WAIT = 3'd2,
        RX_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   cmd_sr;
    logic [BIW-1:0]  byte_idx;
    logic [RLW-1:0]  resp_len_q;
    logic            chk_ack_q;
    logic [TW-1:0]   tmo_cnt;
    logic            rx_take;

    // Handshakes: trmt is a one-cycle strobe with tx_data held until tx_done;
    // rx_rdy is a level that the receiver drops one edge after our one-cycle
    // clr_rx_rdy, so a byte is only taken while clr_rx_rdy is low.
    assign rx_take   = rx_rdy && !clr_rx_rdy;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_sr     <= '0;
            byte_idx   <= '0;
            resp_len_q <= '0;
            chk_ack_q  <= 1'b0;
            tmo_cnt    <= '0;
            tx_data    <= '0;
            trmt       <= 1'b0;
            clr_rx_rdy <= 1'b0;
            busy       <= 1'b0;
            cmd_sent   <= 1'b0;
            resp       <= '0;
            resp_vld   <= 1'b0;
            resp_cnt   <= '0;
            done       <= 1'b0;
            nak        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            trmt       <= 1'b0;
            cmd_sent   <= 1'b0;
            resp_vld   <= 1'b0;
            done       <= 1'b0;
            // Bytes arriving outside the response window are discarded.
            clr_rx_rdy <= (state != RX_WAIT) && rx_take;

            case (state)
                IDLE: begin
                    if (send_cmd) begin
                        tx_data    <= cmd[CW-1 -: 8];
                        cmd_sr     <= cmd << 8;
                        trmt       <= 1'b1;
                        byte_idx   <= '0;
                        resp_len_q <= (resp_len > MAX_LEN) ? MAX_LEN : resp_len;
                        chk_ack_q  <= chk_ack;
                        nak        <= 1'b0;
                        timeout    <= 1'b0;
                        resp_cnt   <= '0;
                        tmo_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= TX_LOAD;
                    end
                end

                TX_LOAD: state <= TX_WAIT;

                TX_WAIT: begin
                    if (tx_done) begin
                        if (byte_idx == LAST_BYTE) begin
                            cmd_sent <= 1'b1;
                            tmo_cnt  <= '0;
                            if (resp_len_q == '0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end else begin
                                state <= RX_WAIT;
                            end
                        end else begin
                            byte_idx <= byte_idx + BIW'(1);
                            tx_data  <= cmd_sr[CW-1 -: 8];
                            cmd_sr   <= cmd_sr << 8;
                            trmt     <= 1'b1;
                            state    <= TX_LOAD;
                        end
                    end
                end

                RX_WAIT: begin
                    if (rx_take) begin
                        resp       <= rx_data;
                        resp_vld   <= 1'b1;
                        clr_rx_rdy <= 1'b1;
                        resp_cnt   <= resp_cnt + RLW'(1);
                        tmo_cnt    <= '0;
                        if (resp_cnt == '0 && chk_ack_q && rx_data != ACK_VAL)
                            nak <= 1'b1;
                        if (resp_cnt + RLW'(1) == resp_len_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
